// File: rtl/muldiv_unit.sv
// RISC-V M-extension execution unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Sign-magnitude datapath with iterative shift-add multiply (or single-cycle) and restoring divide.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_op1,
  input  logic [XLEN-1:0] in_op2,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  acc_hi;
  logic [XLEN-1:0]  acc_lo;
  logic [XLEN-1:0]  opb;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] mul_select(input logic [2:0] op, input logic [2*XLEN-1:0] p);
    return (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_select(input logic [2:0] op, input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r, input logic s1,
                                                 input logic s2);
    case (op)
      OP_DIV:  return cond_neg(q, s1 ^ s2);
      OP_DIVU: return q;
      OP_REM:  return cond_neg(r, s1);
      default: return r;
    endcase
  endfunction

  // Accept-side decode: operand signs, magnitudes and the no-iteration cases.
  logic              sign1_used;
  logic              sign2_used;
  logic              s1_in;
  logic              s2_in;
  logic [XLEN-1:0]   mag1_in;
  logic [XLEN-1:0]   mag2_in;
  logic              is_div_in;
  logic              div_ovf;
  logic [2*XLEN-1:0] fast_prod;
  logic              special;
  logic [XLEN-1:0]   special_res;

  assign sign1_used = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                      (in_op == OP_DIV)  || (in_op == OP_REM);
  assign sign2_used = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
  assign s1_in      = sign1_used && in_op1[XLEN-1];
  assign s2_in      = sign2_used && in_op2[XLEN-1];
  assign mag1_in    = cond_neg(in_op1, s1_in);
  assign mag2_in    = cond_neg(in_op2, s2_in);
  assign is_div_in  = in_op[2];
  assign div_ovf    = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                      (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&in_op2);
  assign fast_prod  = {{XLEN{1'b0}}, mag1_in} * {{XLEN{1'b0}}, mag2_in};

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (is_div_in && (in_op2 == '0)) begin
      special_res = in_op[1] ? in_op1 : '1;
    end else if (div_ovf) begin
      special_res = in_op[1] ? '0 : in_op1;
    end else if (!is_div_in && (FAST_MUL != 0)) begin
      special_res = mul_select(in_op, cond_neg_wide(fast_prod, s1_in ^ s2_in));
    end else begin
      special = 1'b0;
    end
  end

  // One iteration step: shift-add multiply on {acc_hi, acc_lo}, restoring divide with
  // acc_hi as partial remainder and acc_lo shifting dividend bits out / quotient bits in.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_nx;
  logic [XLEN-1:0] mul_lo_nx;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_hi_nx;
  logic [XLEN-1:0] div_lo_nx;
  logic            last_iter;
  logic [XLEN-1:0] calc_res;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign mul_hi_nx = mul_sum[XLEN:1];
  assign mul_lo_nx = {mul_sum[0], acc_lo[XLEN-1:1]};

  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb};
  // When div_ge holds the true difference is below opb, so the low XLEN bits are exact.
  assign div_diff  = div_shift[XLEN-1:0] - opb;
  assign div_hi_nx = div_ge ? div_diff : div_shift[XLEN-1:0];
  assign div_lo_nx = {acc_lo[XLEN-2:0], div_ge};

  assign last_iter = (cnt == CNT_W'(XLEN-1));
  assign calc_res  = op_q[2] ? div_select(op_q, div_lo_nx, div_hi_nx, s1_q, s2_q)
                             : mul_select(op_q, cond_neg_wide({mul_hi_nx, mul_lo_nx}, s1_q ^ s2_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      op_q       <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt        <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opb        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!kill && in_valid) begin
            op_q     <= in_op;
            s1_q     <= s1_in;
            s2_q     <= s2_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (special) begin
              out_result <= special_res;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              acc_hi <= '0;
              acc_lo <= mag1_in;
              opb    <= mag2_in;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            acc_hi <= op_q[2] ? div_hi_nx : mul_hi_nx;
            acc_lo <= op_q[2] ? div_lo_nx : mul_lo_nx;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              out_result <= calc_res;
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: begin
          if (kill || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: three instances (32-bit iterative, 32-bit fast multiply,
// 16-bit iterative) sharing stimulus, with one instance selected per transaction.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        kill;
  logic        out_ready;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [1:0]  sel;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [31:0] res0, res1;
  logic [15:0] res2;
  logic        cur_ir, cur_ov;
  logic [31:0] cur_res;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .FAST_MUL(0)) u_slow (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd0)), .in_ready(ir0),
    .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .kill(kill),
    .out_valid(ov0), .out_ready(out_ready), .out_result(res0)
  );

  muldiv_unit #(.XLEN(32), .FAST_MUL(1)) u_fast (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd1)), .in_ready(ir1),
    .in_op(in_op), .in_op1(in_op1), .in_op2(in_op2), .kill(kill),
    .out_valid(ov1), .out_ready(out_ready), .out_result(res1)
  );

  muldiv_unit #(.XLEN(16), .FAST_MUL(0)) u_x16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd2)), .in_ready(ir2),
    .in_op(in_op), .in_op1(in_op1[15:0]), .in_op2(in_op2[15:0]), .kill(kill),
    .out_valid(ov2), .out_ready(out_ready), .out_result(res2)
  );

  always_comb begin
    cur_ir  = ir0;
    cur_ov  = ov0;
    cur_res = res0;
    case (sel)
      2'd1: begin cur_ir = ir1; cur_ov = ov1; cur_res = res1; end
      2'd2: begin cur_ir = ir2; cur_ov = ov2; cur_res = {16'h0, res2}; end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle, then scramble the operand bus.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_op    = op;
    in_op1   = a;
    in_op2   = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_op    = ~op;
    in_op1   = ~a;
    in_op2   = ~b;
  endtask

  task automatic wait_result(output int lat, output logic [31:0] res);
    lat = 1;
    while (!cur_ov && lat < 100) begin
      tick();
      lat++;
    end
    res = cur_res;
    checks++;
    if (cur_ov !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", cur_ov, lat);
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #0;
      checks++;
      if (cur_ir !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b, required 1", i, cur_ir);
      end
      checks++;
      if (cur_ov !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid[%0d]: got %b, required 0", i, cur_ov);
      end
      checks++;
      if (cur_res !== 32'h0) begin
        errors++;
        $display("FAIL reset_out_result[%0d]: got %h, required 0", i, cur_res);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'hFFFFFF9C, 32'hFFFFFF9C};
    logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd2, 32'd2,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] exs [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1,
                             32'hFFFFFFF2, 32'h2, 32'hE, 32'hFFFFFFFE};
    int lat;
    logic [31:0] res;
    sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_result(lat, res);
      checks++;
      if (res !== exs[i]) begin
        errors++;
        $display("FAIL div[%0d] op%0d: got %h, required %h", i, ops[i], res, exs[i]);
      end
      checks++;
      if (lat != 33) begin
        errors++;
        $display("FAIL div_latency[%0d]: got %0d, required 33", i, lat);
      end
      release_result();
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  ops [6] = '{3'd4, 3'd5, 3'd7, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [6] = '{32'h55, 32'd7, 32'h1234, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] bs  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exs [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFF9,
                             32'h80000000, 32'h0};
    int lat;
    logic [31:0] res;
    sel = 2'd0;
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_result(lat, res);
      checks++;
      if (res !== exs[i]) begin
        errors++;
        $display("FAIL div_special[%0d] op%0d: got %h, required %h", i, ops[i], res, exs[i]);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL div_special_latency[%0d]: got %0d, required 1", i, lat);
      end
      release_result();
    end
  endtask

  task automatic test_mul(input logic [1:0] unit, input int exp_lat);
    logic [2:0]  ops [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2};
    logic [31:0] as  [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h2};
    logic [31:0] bs  [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h5, 32'h5, 32'hFFFFFFFB, 32'hFFFFFFFF};
    logic [31:0] exs [8] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,
                             32'hFFFFFFF1, 32'hFFFFFFFF, 32'h0, 32'h1};
    int lat;
    logic [31:0] res;
    sel = unit;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_result(lat, res);
      checks++;
      if (res !== exs[i]) begin
        errors++;
        $display("FAIL mul[%0d] unit%0d op%0d: got %h, required %h", i, unit, ops[i], res, exs[i]);
      end
      checks++;
      if (lat != exp_lat) begin
        errors++;
        $display("FAIL mul_latency[%0d] unit%0d: got %0d, required %0d", i, unit, lat, exp_lat);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] res;
    sel = 2'd0;
    start_op(3'd5, 32'd100, 32'd7);
    wait_result(lat, res);
    checks++;
    if (res !== 32'd14) begin
      errors++;
      $display("FAIL bp_result: got %h, required %h", res, 32'd14);
    end
    in_op    = 3'd4;
    in_op1   = 32'h99;
    in_op2   = 32'h0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (cur_ov !== 1'b1 || cur_res !== 32'd14 || cur_ir !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b result=%h in_ready=%b, required 1/%h/0",
                 i, cur_ov, cur_res, cur_ir, 32'd14);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (cur_ir !== 1'b1 || cur_ov !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b valid=%b, required 1/0", cur_ir, cur_ov);
    end
  endtask

  task automatic test_kill();
    int lat;
    logic [31:0] res;
    logic seen;
    sel = 2'd0;
    start_op(3'd4, 32'hFFFFFFF9, 32'd2);
    repeat (4) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checks++;
    if (cur_ir !== 1'b1 || cur_ov !== 1'b0) begin
      errors++;
      $display("FAIL kill_calc: in_ready=%b valid=%b, required 1/0", cur_ir, cur_ov);
    end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (cur_ov) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL kill_no_result: out_valid seen=%b, required 0", seen);
    end
    start_op(3'd0, 32'd6, 32'd7);
    wait_result(lat, res);
    checks++;
    if (res !== 32'd42 || lat != 33) begin
      errors++;
      $display("FAIL kill_next_mul: got %h lat %0d, required %h lat 33", res, lat, 32'd42);
    end
    release_result();
    // kill in IDLE blocks a request that would otherwise finish next cycle
    in_op    = 3'd4;
    in_op1   = 32'h5;
    in_op2   = 32'h0;
    in_valid = 1'b1;
    kill     = 1'b1;
    tick();
    in_valid = 1'b0;
    kill     = 1'b0;
    tick();
    checks++;
    if (cur_ov !== 1'b0 || cur_ir !== 1'b1) begin
      errors++;
      $display("FAIL kill_idle: valid=%b in_ready=%b, required 0/1", cur_ov, cur_ir);
    end
    start_op(3'd4, 32'h5, 32'h0);
    checks++;
    if (cur_ov !== 1'b1) begin
      errors++;
      $display("FAIL kill_done_setup: valid=%b, required 1", cur_ov);
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checks++;
    if (cur_ov !== 1'b0 || cur_ir !== 1'b1) begin
      errors++;
      $display("FAIL kill_done: valid=%b in_ready=%b, required 0/1", cur_ov, cur_ir);
    end
  endtask

  task automatic test_x16();
    logic [2:0]  ops [5] = '{3'd4, 3'd5, 3'd6, 3'd3, 3'd0};
    logic [31:0] as  [5] = '{32'h8000, 32'hFFFF, 32'hFFF9, 32'hFFFF, 32'd6};
    logic [31:0] bs  [5] = '{32'hFFFF, 32'd3, 32'd2, 32'hFFFF, 32'd7};
    logic [31:0] exs [5] = '{32'h8000, 32'h5555, 32'hFFFF, 32'hFFFE, 32'h2A};
    int          lts [5] = '{1, 17, 17, 17, 17};
    int lat;
    logic [31:0] res;
    logic seen;
    sel = 2'd2;
    for (int i = 0; i < 5; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_result(lat, res);
      checks++;
      if (res !== exs[i]) begin
        errors++;
        $display("FAIL x16[%0d] op%0d: got %h, required %h", i, ops[i], res, exs[i]);
      end
      checks++;
      if (lat != lts[i]) begin
        errors++;
        $display("FAIL x16_latency[%0d]: got %0d, required %0d", i, lat, lts[i]);
      end
      release_result();
    end
    start_op(3'd5, 32'hFFFF, 32'd3);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (cur_ir !== 1'b1 || cur_ov !== 1'b0) begin
      errors++;
      $display("FAIL x16_reset_mid_calc: in_ready=%b valid=%b, required 1/0", cur_ir, cur_ov);
    end
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (cur_ov) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL x16_reset_no_result: out_valid seen=%b, required 0", seen);
    end
  endtask

  initial begin
    rst       = 1'b1;
    kill      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_op1    = 32'h0;
    in_op2    = 32'h0;
    sel       = 2'd0;
    test_reset();
    test_div();
    test_div_special();
    test_mul(2'd0, 33);
    test_mul(2'd1, 1);
    test_backpressure();
    test_kill();
    test_x16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RISC-V M-extension execution unit covering MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage, which hands M-extension operations to this unit.
- Uses a valid/ready handshake on both the request side and the result side.
- Width is set by XLEN. Multiply is either iterative or single-cycle, selected by FAST_MUL. Divide is always iterative (restoring, radix-2).

Parameters:
- XLEN, 32: operand and result width in bits; must be at least 8 and even.
- FAST_MUL, 0: 1 = multiply result valid 1 cycle after accept; 0 = multiply is iterative shift-add over XLEN cycles.

Ports:
- clk  in  1  sole clock. Timing: one clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  operation (RISC-V funct3): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_op1  in  XLEN  rs1 value.
- in_op2  in  XLEN  rs2 value.
- kill  in  1  abort the in-flight operation (pipeline flush).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.

Behaviour:
- States: IDLE, CALC, DONE.
- in_ready is 1 only in IDLE. A request is accepted when in_valid && in_ready.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0. Internal counter and accumulators are cleared.
- Reset mid-operation: the operation is dropped and no result is produced.

On accept:
- Latch op, operand signs and magnitudes:
  - s1 = op1[XLEN-1] for MULH, MULHSU, DIV, REM; otherwise 0.
  - s2 = op2[XLEN-1] for MULH, DIV, REM; otherwise 0.
  - Magnitude = two's-complement negation when the sign bit is 1, otherwise the raw value. The most negative value maps to itself as an unsigned magnitude.
- Special cases resolve without iteration and go directly to DONE (out_valid 1 cycle after accept):
  - DIV or DIVU with op2==0: result is all ones.
  - REM or REMU with op2==0: result is op1.
  - DIV with op1 = 1 followed by XLEN-1 zeros and op2 = all ones: result is op1.
  - REM with the same operands: result is 0.
- Multiply with FAST_MUL=1 goes directly to DONE with the result computed on accept.
- All other operations enter CALC with counter=0.

CALC:
- One iteration per cycle. Leaves for DONE after the iteration with counter==XLEN-1.
- out_valid asserts exactly XLEN+1 cycles after the accept cycle.
- Multiply: 2*XLEN-bit unsigned product of the magnitudes, one shift-add step per cycle.
- Divide: restoring division on the magnitudes, producing quotient and remainder.

On entering DONE (sign fix):
- Product is negated over the full 2*XLEN bits when s1^s2.
- MUL returns product[XLEN-1:0]. MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- DIV quotient is negated when s1^s2. REM remainder is negated when s1. DIVU and REMU are unmodified.

DONE:
- out_valid=1. out_result is held stable until out_ready.
- When out_valid && out_ready, go to IDLE next cycle. No new request is accepted in that same cycle.
- out_valid stays high indefinitely while out_ready=0.

kill:
- In CALC or DONE: go to IDLE next cycle and drop out_valid; no result is delivered.
- In IDLE: takes priority over in_valid, so no request is accepted that cycle.
- kill has lower priority than rst.

Operand inputs are sampled only on accept; changes afterwards have no effect.

Test Plan:
- XLEN=32, FAST_MUL=0, DIV op1=-7 (0xFFFFFFF9), op2=2 -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). DIVU with the same operands -> 0x7FFFFFFC.
- DIV op2=0 -> 0xFFFFFFFF one cycle after accept. REMU op1=0x1234, op2=0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MUL of the same operands -> 0x00000001. Run with FAST_MUL=0 (latency 33) and FAST_MUL=1 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_result stable, in_ready=0. Assert out_ready -> IDLE next cycle, in_ready=1.
- kill at cycle 5 of a DIV -> no out_valid. The next request, MUL 6*7, returns 42.
- XLEN=16: DIV 0x8000 / 0xFFFF -> 0x8000. DIVU 0xFFFF / 3 -> 0x5555 with latency 17. rst asserted mid-CALC -> in_ready=1 and out_valid=0 next cycle.
